simmem_release_scheduler: RTL
=============================

# simmem_release_scheduler

Sequencing controller between the delay calculator release-enable outputs and a response bank's single output port. Takes the multi-hot set of entries whose simulated delay has elapsed, picks one per cycle with fair round-robin, and presents it as a stable valid/ready grant. On each completed handshake it returns the one-hot release confirmation that the delay calculator consumes on `wrsp_released_iid_onehot_i` / `rdata_released_iid_onehot_i`. One instance sits on the write-response path and one on the read-data path.

## Interface
- `Capa`, default `simmem_pkg::WRspBankCapa`: number of bank entries; any value ≥ 2, not necessarily a power of two.
- `IidW`, default `$clog2(Capa)`: internal-identifier width.
- `clk_i`  in  1: single clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `en_i`  in  1: scheduler enable; when low, no new grant is issued, but a grant already in flight completes.
- `release_en_mhot_i`  in  Capa: delay calculator release enables; bit k means entry k may be released.
- `grant_valid_o`  out  1: a grant is presented.
- `grant_ready_i`  in  1: bank output port accepts the grant.
- `grant_iid_o`  out  IidW: granted entry index.
- `grant_onehot_o`  out  Capa: one-hot of `grant_iid_o`; all zeros when `grant_valid_o` is low.
- `released_iid_onehot_o`  out  Capa: release confirmation, equal to `grant_onehot_o & {Capa{grant_valid_o & grant_ready_i}}`.
- `released_cnt_o`  out  32: count of completed handshakes since reset; wraps modulo 2^32.

## Operation
- State `IDLE`, `GRANT`. Registers: `rr_ptr_q` (IidW), `grant_iid_q`, `released_cnt_q`.
- Candidate set: `release_en_mhot_i`, with the current grant bit masked while in `GRANT`, gated by `en_i`.
- Selection: lowest candidate index ≥ `rr_ptr_q`; if there is none, lowest candidate index overall (wrap). Implement as a double-width masked priority encode. No out-of-range index is ever produced for non-power-of-two `Capa`.
- `IDLE`:
  - Candidate present: latch the selection into `grant_iid_q` and go to `GRANT`.
  - No candidate: stay in `IDLE`.
- `GRANT`:
  - `grant_valid_o = 1`. `grant_iid_o` and `grant_onehot_o` stay stable until the handshake.
  - Deassertion of the granted enable bit, or `en_i` going low, does not withdraw the grant.
- Handshake (`grant_valid_o & grant_ready_i`):
  - Pulse `released_iid_onehot_o` in the same cycle.
  - Increment `released_cnt_q`.
  - `rr_ptr_q <= (grant_iid_q == Capa-1) ? 0 : grant_iid_q + 1`.
  - If a candidate exists (selection uses the updated pointer value, computed combinationally), latch it and stay in `GRANT`. Otherwise go to `IDLE`.
- No valid while ready is low and in `GRANT`: hold.
- The delay calculator clears an entry's enable only after seeing the release confirmation, so masking the granted bit prevents a double grant in back-to-back operation.

## Timing
- Reset values: state `IDLE`, `rr_ptr_q = 0`, `grant_iid_q = 0`, `released_cnt_q = 0`. Outputs: `grant_valid_o = 0`, `grant_iid_o = 0`, `grant_onehot_o = 0`, `released_iid_onehot_o = 0`, `released_cnt_o = 0`.
- Reset asserted mid-grant: the grant is dropped the next cycle with no release pulse. The bench must re-drive enables.
- Latency from enable to grant: 1 cycle, meaning an enable seen at edge n gives `grant_valid_o` high after edge n.
- Throughput: 1 grant per cycle while `grant_ready_i` stays high and candidates remain.
- `released_iid_onehot_o` is combinational from `grant_ready_i`. It has zero latency and is never registered.
- `grant_ready_i` has no combinational path to `grant_valid_o`.
- `en_i` low with an enable pending: stays in `IDLE` indefinitely. Grant occurs 1 cycle after `en_i` rises.

## Structure
- Shared constants (`WRspBankCapa`, `RDataBankCapa`) are taken from `simmem_pkg`; no new package types.
- Add a package function `rr_select(mhot, ptr)` only if a second user appears; otherwise keep it local.
- One sub-module: `simmem_rr_picker` (combinational masked priority encoder, Capa-wide in, IidW index plus found flag out). It is reusable by the bank's other arbitration points.

## Test plan
- Single enable: `Capa = 8`, bit 5 set, ready high → `grant_valid_o` the cycle after, `grant_iid_o = 5`, `released_iid_onehot_o = 8'b0010_0000` that cycle, `rr_ptr = 6`, `released_cnt_o = 1`.
- Round-robin fairness: bits {1,3,6} held high, ready always high → grants 1, 3, 6, 1, 3, 6 on consecutive cycles with no idle cycles.
- Backpressure stability: grant 2 with ready low for 5 cycles; enable bit 2 dropped and bit 4 raised during the hold → `grant_iid_o` stays 2 throughout; after ready, grant 4 on the next cycle.
- Wrap with non-power-of-two `Capa = 6`: `rr_ptr` at 5, bits {0,5} → grant 5, then 0. `grant_iid_o` never ≥ 6.
- Enable gating: `en_i` low with bit 3 set → no grant for 10 cycles; `en_i` high → grant 3 one cycle later. `en_i` dropped during a held grant → that grant still completes.
- Reset mid-grant: grant 7 pending with ready low, assert `rst_i` → next cycle all outputs zero, no release pulse, `released_cnt_o = 0`.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared constants for the simulated-memory response banks.
package simmem_pkg;

  // Number of entries held by the write-response bank.
  localparam int unsigned WRspBankCapa = 8;

  // Number of entries held by the read-data bank.
  localparam int unsigned RDataBankCapa = 16;

endpackage

// File: rtl/simmem_rr_picker.sv
// Combinational round-robin picker: returns the lowest set bit at or above
// ptr, wrapping to the lowest set bit overall when nothing lies above ptr.
module simmem_rr_picker #(
  parameter int unsigned Capa = 8,
  parameter int unsigned IidW = $clog2(Capa)
) (
  input  logic [Capa-1:0] mhot,
  input  logic [IidW-1:0] ptr,
  output logic [IidW-1:0] idx,
  output logic            found
);

  // The low half holds only requests at or above the pointer and the high
  // half holds every request, so the lowest set bit of the doubled vector is
  // the round-robin winner and the wrap case falls out of the same search.
  logic [2*Capa-1:0] dbl;

  // Build the doubled, pointer-masked request vector.
  always_comb begin
    dbl = '0;
    for (int i = 0; i < int'(Capa); i++) begin
      dbl[i]        = mhot[i] & (i >= int'(ptr));
      dbl[Capa + i] = mhot[i];
    end
  end

  // Priority-encode the lowest set bit and fold it back into 0..Capa-1, so a
  // non-power-of-two Capa can never yield an index at or above Capa.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 2 * int'(Capa) - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        if (i >= int'(Capa)) begin
          idx = IidW'(i - int'(Capa));
        end else begin
          idx = IidW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Release scheduler: picks one released entry per cycle round-robin, holds it
// as a stable valid/ready grant and confirms each completed handshake one-hot.
module simmem_release_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned Capa = WRspBankCapa,
  parameter int unsigned IidW = $clog2(Capa)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [Capa-1:0] release_en_mhot_i,
  output logic            grant_valid_o,
  input  logic            grant_ready_i,
  output logic [IidW-1:0] grant_iid_o,
  output logic [Capa-1:0] grant_onehot_o,
  output logic [Capa-1:0] released_iid_onehot_o,
  output logic [31:0]     released_cnt_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e          state_q;
  logic [IidW-1:0] rr_ptr_q;
  logic [IidW-1:0] grant_iid_q;
  logic [31:0]     released_cnt_q;

  logic            grant_active;
  logic            handshake;
  logic [Capa-1:0] grant_mask;
  logic [IidW-1:0] ptr_after;
  logic [IidW-1:0] sel_ptr;
  logic [Capa-1:0] cand;
  logic [IidW-1:0] pick_idx;
  logic            pick_found;

  assign grant_active = (state_q == GRANT);
  assign handshake    = grant_active & grant_ready_i;

  // Decode the held grant index into a one-hot mask.
  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < int'(Capa); i++) begin
      grant_mask[i] = (grant_iid_q == IidW'(i));
    end
  end

  // Pointer after a handshake, wrapping explicitly at Capa-1 so that a
  // non-power-of-two Capa never walks into unused index values.
  always_comb begin
    if (grant_iid_q == IidW'(Capa - 1)) begin
      ptr_after = '0;
    end else begin
      ptr_after = grant_iid_q + 1'b1;
    end
  end

  // On a handshake the next pick already uses the advanced pointer so that
  // back-to-back grants rotate fairly without an idle cycle.
  always_comb begin
    sel_ptr = handshake ? ptr_after : rr_ptr_q;
  end

  // The granted bit stays high until the delay calculator sees the
  // confirmation, so it is masked out to avoid granting it twice in a row.
  always_comb begin
    cand = release_en_mhot_i & {Capa{en_i}};
    if (grant_active) begin
      cand = cand & ~grant_mask;
    end
  end

  simmem_rr_picker #(
    .Capa (Capa),
    .IidW (IidW)
  ) u_picker (
    .mhot  (cand),
    .ptr   (sel_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant FSM: latch a pick when idle, hold it until accepted, then either
  // chain straight into the next pick or fall back to idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_iid_q    <= '0;
      released_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_iid_q <= pick_idx;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready_i) begin
            released_cnt_q <= released_cnt_q + 32'd1;
            rr_ptr_q       <= ptr_after;
            if (pick_found) begin
              grant_iid_q <= pick_idx;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign grant_valid_o         = grant_active;
  assign grant_iid_o           = grant_iid_q;
  assign grant_onehot_o        = grant_mask & {Capa{grant_active}};
  assign released_iid_onehot_o = grant_onehot_o & {Capa{handshake}};
  assign released_cnt_o        = released_cnt_q;

endmodule
